// File: rtl/ps2_host_tx_if.sv
// Host-side command interface for the PS/2 transmitter.
//   tx_data  : byte to send, captured when tx_start is accepted
//   tx_start : one-cycle send request, ignored while tx_busy=1
//   tx_busy  : transmitter owns the PS/2 lines (receiver must ignore them)
//   tx_done  : one-cycle pulse, frame sent and ACK seen
//   tx_error : one-cycle pulse, timeout or missing ACK
// master = command issuer, slave = transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   modport master (output tx_data, output tx_start,
                   input  tx_busy, input  tx_done, input tx_error);
   modport slave  (input  tx_data, input  tx_start,
                   output tx_busy, output tx_done, output tx_error);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts 8 data bits + odd parity + stop on device clock falls, checks the ACK.
// Ports:
//   clk14      : 14 MHz master clock
//   rst_n      : async active-low reset, releases both lines immediately
//   host       : command interface (tx_data/tx_start in, tx_busy/tx_done/tx_error out)
//   ps2_clk_in : raw PS/2 clock line (async)
//   ps2_dat_in : raw PS/2 data line (async)
//   ps2_clk_oe : 1 = pull PS/2 clock low
//   ps2_dat_oe : 1 = pull PS/2 data low
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYC  = 1540,
   parameter int unsigned RTS_HOLD_CYC = 28,
   parameter int unsigned START_TO_CYC = 210000,
   parameter int unsigned PKT_TO_CYC   = 28000
) (
   input  logic          clk14,
   input  logic          rst_n,
   ps2_host_tx_if.slave  host,
   input  logic          ps2_clk_in,
   input  logic          ps2_dat_in,
   output logic          ps2_clk_oe,
   output logic          ps2_dat_oe
);

   localparam int unsigned CNT_W   = 18;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned FRAME_W = 10;

   typedef enum logic [3:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_WAIT1, S_SHIFT,
      S_ACK, S_IDLEWAIT, S_DONE, S_ERR
   } state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [CNT_W-1:0]     pkt, pkt_d;
   logic [IDX_W-1:0]     idx, idx_d;
   logic [FRAME_W-1:0]   frame, frame_d;
   logic                 clk_oe_d, dat_oe_d, busy_d, done_d, err_d;

   logic clk_meta, sync_clk, sync_clk_d, dat_meta, sync_dat;
   logic fall_c;

   // Two-flop synchronisers; reset to idle-high so no false fall follows reset.
   always_ff @(posedge clk14 or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta   <= 1'b1;
         sync_clk   <= 1'b1;
         sync_clk_d <= 1'b1;
         dat_meta   <= 1'b1;
         sync_dat   <= 1'b1;
      end else begin
         clk_meta   <= ps2_clk_in;
         sync_clk   <= clk_meta;
         sync_clk_d <= sync_clk;
         dat_meta   <= ps2_dat_in;
         sync_dat   <= dat_meta;
      end
   end

   assign fall_c = sync_clk_d & ~sync_clk;

   // State, counters and registered outputs.
   always_ff @(posedge clk14 or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         pkt           <= '0;
         idx           <= '0;
         frame         <= '0;
         ps2_clk_oe    <= 1'b0;
         ps2_dat_oe    <= 1'b0;
         host.tx_busy  <= 1'b0;
         host.tx_done  <= 1'b0;
         host.tx_error <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         pkt           <= pkt_d;
         idx           <= idx_d;
         frame         <= frame_d;
         ps2_clk_oe    <= clk_oe_d;
         ps2_dat_oe    <= dat_oe_d;
         host.tx_busy  <= busy_d;
         host.tx_done  <= done_d;
         host.tx_error <= err_d;
      end
   end

   // Next state; outputs are decoded from the state being entered so they
   // line up with the state register.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt + CNT_W'(1);
      pkt_d    = pkt;
      idx_d    = idx;
      frame_d  = frame;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state)
         S_IDLE: begin
            if (host.tx_start) begin
               frame_d = {1'b1, ~^host.tx_data, host.tx_data};
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt == CNT_W'(INHIBIT_CYC - 1)) state_d = S_RTS;
         end
         S_RTS: begin
            if (cnt == CNT_W'(RTS_HOLD_CYC - 1)) state_d = S_WAIT1;
         end
         S_WAIT1: begin
            pkt_d = '0;
            if (fall_c) begin
               idx_d   = '0;
               state_d = S_SHIFT;
            end else if (cnt == CNT_W'(START_TO_CYC)) begin
               state_d = S_ERR;
            end
         end
         S_SHIFT: begin
            pkt_d = pkt + CNT_W'(1);
            if (pkt == CNT_W'(PKT_TO_CYC)) begin
               state_d = S_ERR;
            end else if (fall_c) begin
               idx_d = idx + IDX_W'(1);
               // Fall that would present the stop bit: release data instead.
               if (idx == IDX_W'(FRAME_W - 2)) state_d = S_ACK;
            end
         end
         S_ACK: begin
            pkt_d = pkt + CNT_W'(1);
            if (pkt == CNT_W'(PKT_TO_CYC)) state_d = S_ERR;
            else if (fall_c)               state_d = sync_dat ? S_ERR : S_IDLEWAIT;
         end
         S_IDLEWAIT: begin
            pkt_d = pkt + CNT_W'(1);
            if (pkt == CNT_W'(PKT_TO_CYC))  state_d = S_ERR;
            else if (sync_clk && sync_dat)  state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state || state_d == S_IDLE) cnt_d = '0;

      clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
      case (state_d)
         S_RTS, S_WAIT1: dat_oe_d = 1'b1;
         S_SHIFT:        dat_oe_d = ~frame_d[idx_d];
         default:        dat_oe_d = 1'b0;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed + randomized bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

   localparam int unsigned INHIBIT_CYC  = 1540;
   localparam int unsigned RTS_HOLD_CYC = 28;
   localparam int unsigned START_TO_CYC = 3000;
   localparam int unsigned PKT_TO_CYC   = 1500;
   localparam int          HALF         = 20;

   logic clk14 = 1'b0;
   logic rst_n = 1'b0;
   logic ps2_clk_oe, ps2_dat_oe;
   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;
   wire  ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   wire  ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int both_cnt = 0;

   ps2_host_tx_if ifc ();

   ps2_host_tx #(
      .INHIBIT_CYC  (INHIBIT_CYC),
      .RTS_HOLD_CYC (RTS_HOLD_CYC),
      .START_TO_CYC (START_TO_CYC),
      .PKT_TO_CYC   (PKT_TO_CYC)
   ) dut (
      .clk14      (clk14),
      .rst_n      (rst_n),
      .host       (ifc.slave),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #5 clk14 = ~clk14;

   always @(posedge clk14) begin
      if (ifc.tx_done)                 done_cnt++;
      if (ifc.tx_error)                err_cnt++;
      if (ifc.tx_done && ifc.tx_error) both_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk14);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected wire bits after the start bit: data LSB first, odd parity, stop.
   function automatic logic [9:0] ref_bits(input logic [7:0] b);
      logic [9:0] r;
      int ones = 0;
      for (int i = 0; i < 8; i++) begin
         r[i] = ((b >> i) % 2) == 1;
         ones += ((b >> i) % 2);
      end
      r[8] = (ones % 2) == 0;
      r[9] = 1'b1;
      return r;
   endfunction

   // Issue a command and measure the inhibit / request-to-send phases.
   task automatic send_start(input logic [7:0] b, input bit poke, input string tag);
      int inh = 0;
      int rts = 0;
      int guard = 0;
      ifc.tx_data  = b;
      ifc.tx_start = 1'b1;
      tick();
      ifc.tx_start = 1'b0;
      chk({tag, "_busy_on_accept"}, 32'(ifc.tx_busy), 32'd1);
      while (ps2_clk_oe && guard < 5000) begin
         if (ps2_dat_oe) rts++;
         else            inh++;
         if (poke && inh == 100) begin
            ifc.tx_data  = 8'hFF;
            ifc.tx_start = 1'b1;
         end else begin
            ifc.tx_start = 1'b0;
         end
         guard++;
         tick();
      end
      ifc.tx_start = 1'b0;
      chk({tag, "_inhibit_cyc"}, 32'(inh), 32'(INHIBIT_CYC));
      chk({tag, "_rts_cyc"}, 32'(rts), 32'(RTS_HOLD_CYC));
      chk({tag, "_start_bit_low"}, 32'(ps2_dat_oe), 32'd1);
   endtask

   // Device side: clock the 11 falls, sample on each rise, optionally ACK.
   task automatic run_frame(input logic [7:0] b, input bit ack_ok, input bit poke, input string tag);
      logic [9:0] got = '0;
      logic       clk_pulled = 1'b0;
      int d0, e0;
      bit seen = 0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_start(b, poke, tag);
      repeat (10) tick();
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         for (int c = 0; c < HALF; c++) begin
            if (ps2_clk_oe) clk_pulled = 1'b1;
            tick();
         end
         if (k <= 10) got[k-1] = ps2_dat_in;
         dev_clk_low = 1'b0;
         if (k == 10 && ack_ok) dev_dat_low = 1'b1;
         if (k < 11) repeat (HALF) tick();
      end
      tick();
      dev_dat_low = 1'b0;
      chk({tag, "_wire_bits"}, 32'(got), 32'(ref_bits(b)));
      chk({tag, "_clk_not_driven"}, 32'(clk_pulled), 32'd0);
      if (ack_ok) begin
         for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (ifc.tx_done) begin
               seen = 1;
               chk({tag, "_busy_with_done"}, 32'(ifc.tx_busy), 32'd1);
               tick();
               chk({tag, "_busy_after_done"}, 32'(ifc.tx_busy), 32'd0);
            end
         end
         chk({tag, "_done_seen"}, 32'(seen), 32'd1);
         tick();
         chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
         chk({tag, "_no_error"}, 32'(err_cnt - e0), 32'd0);
      end else begin
         for (int i = 0; i < 200 && ifc.tx_busy; i++) tick();
         tick();
         chk({tag, "_idle_after_err"}, 32'(ifc.tx_busy), 32'd0);
         chk({tag, "_error_pulses"}, 32'(err_cnt - e0), 32'd1);
         chk({tag, "_no_done"}, 32'(done_cnt - d0), 32'd0);
         chk({tag, "_lines_released"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      end
      repeat (20) tick();
   endtask

   initial begin
      int d0, e0, wait_cyc;
      logic [7:0] rb;
      ifc.tx_data  = 8'h00;
      ifc.tx_start = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, ifc.tx_busy, ifc.tx_done, ifc.tx_error}), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_after_reset", 32'({ps2_clk_oe, ps2_dat_oe, ifc.tx_busy}), 32'd0);

      // Main frame, parity corners, and a command issued while busy.
      run_frame(8'hED, 1'b1, 1'b0, "ed");
      run_frame(8'h00, 1'b1, 1'b0, "x00");
      run_frame(8'h01, 1'b1, 1'b0, "x01");
      run_frame(8'h3C, 1'b1, 1'b1, "busy_poke");

      for (int n = 0; n < 4; n++) begin
         rb = 8'($urandom_range(0, 255));
         run_frame(rb, 1'b1, 1'b0, "rand");
      end

      // Device drops the ACK.
      run_frame(8'hF4, 1'b0, 1'b0, "no_ack");

      // Device never clocks.
      d0 = done_cnt;
      e0 = err_cnt;
      send_start(8'hFF, 1'b0, "silent");
      wait_cyc = 0;
      while (!ifc.tx_error && wait_cyc < int'(START_TO_CYC) + 200) begin
         tick();
         wait_cyc++;
      end
      chk("start_timeout_window",
          32'(wait_cyc >= int'(START_TO_CYC) && wait_cyc <= int'(START_TO_CYC) + 2), 32'd1);
      chk("start_timeout_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      chk("start_timeout_no_done", 32'(ifc.tx_done), 32'd0);
      repeat (3) tick();
      chk("start_timeout_err_pulses", 32'(err_cnt - e0), 32'd1);
      chk("start_timeout_done_pulses", 32'(done_cnt - d0), 32'd0);

      // Reset in the middle of the shift phase.
      send_start(8'hA5, 1'b0, "mid_rst");
      repeat (10) tick();
      for (int k = 0; k < 4; k++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) tick();
         dev_clk_low = 1'b0;
         repeat (HALF) tick();
      end
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      chk("mid_rst_busy_before", 32'(ifc.tx_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_released", 32'({ps2_clk_oe, ps2_dat_oe, ifc.tx_busy}), 32'd0);
      dev_clk_low = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("mid_rst_idle", 32'({ps2_clk_oe, ps2_dat_oe, ifc.tx_busy, ifc.tx_done, ifc.tx_error}), 32'd0);
      run_frame(8'h5A, 1'b1, 1'b0, "after_rst");

      chk("done_error_exclusive", 32'(both_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
